// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch stage: FSM state type, opcodes and
// instruction field positions.
package mips_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_RUN  = 2'd1,
        FETCH_HALT = 2'd2
    } fetch_state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int RS_MSB    = 25;
    localparam int RS_LSB    = 21;
    localparam int RT_MSB    = 20;
    localparam int RT_LSB    = 16;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 11;
    localparam int IMM_MSB   = 15;
    localparam int IMM_LSB   = 0;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;

    // Byte offset of a branch: sign-extended word offset shifted left by two.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_imem.sv
// Instruction memory: one synchronous write port for program load and one
// combinational read port for the single-cycle fetch path.
module imem
    import mips_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [31:0]              wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [31:0]              rdata
);

    // Deliberately no reset: a loaded program must survive rst_n.
    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_fetch.sv
// Single-cycle instruction fetch: program-load/run/halt sequencing, PC
// register with BEQ next-PC logic, and instruction field decode.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   FETCH_IDLE | after reset; program may be loaded; run pulse starts fetch
//   FETCH_RUN  | fetching one instruction per cycle from pc
//   FETCH_HALT | pc ran past the end of memory; left only through reset
module instr_fetch
    import mips_pkg::*;
#(
    parameter int          IMEM_DEPTH = 64,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load_en,
    input  logic [$clog2(IMEM_DEPTH)-1:0] load_addr,
    input  logic [31:0]                   load_data,
    input  logic                          run,
    input  logic                          branch,
    input  logic                          zero,
    output logic [31:0]                   instr,
    output logic                          instr_valid,
    output logic [5:0]                    op,
    output logic [5:0]                    funct,
    output logic [4:0]                    rs,
    output logic [4:0]                    rt,
    output logic [4:0]                    rd,
    output logic [15:0]                   imm,
    output logic [31:0]                   pc,
    output logic [31:0]                   pc_plus4,
    output logic                          halted
);

    localparam int          AW          = $clog2(IMEM_DEPTH);
    localparam logic [29:0] DEPTH_WORDS = 30'(IMEM_DEPTH);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  rdata;
    logic [31:0]  branch_target;
    logic         in_range;
    logic         imem_we;

    assign in_range      = pc_q[31:2] < DEPTH_WORDS;
    assign imem_we       = load_en && (state_q == FETCH_IDLE);
    assign pc_plus4      = pc_q + 32'd4;
    assign branch_target = pc_plus4 + branch_offset(rdata[IMM_MSB:IMM_LSB]);
    assign pc            = pc_q;

    imem #(
        .DEPTH (IMEM_DEPTH)
    ) u_imem (
        .clk   (clk),
        .we    (imem_we),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (pc_q[AW+1:2]),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FETCH_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            FETCH_IDLE: begin
                if (run) begin
                    state_d = FETCH_RUN;
                end
            end
            FETCH_RUN: begin
                if (!in_range) begin
                    state_d = FETCH_HALT;
                end else if (branch && zero) begin
                    pc_d = branch_target;
                end else begin
                    pc_d = pc_plus4;
                end
            end
            FETCH_HALT: state_d = FETCH_HALT;
            default:    state_d = FETCH_IDLE;
        endcase
    end

    always_comb begin
        instr_valid = (state_q == FETCH_RUN) && in_range;
        halted      = (state_q == FETCH_HALT);
        instr       = instr_valid ? rdata : 32'h0;
    end

    assign op    = instr[OP_MSB:OP_LSB];
    assign rs    = instr[RS_MSB:RS_LSB];
    assign rt    = instr[RT_MSB:RT_LSB];
    assign rd    = instr[RD_MSB:RD_LSB];
    assign imm   = instr[IMM_MSB:IMM_LSB];
    assign funct = instr[FUNCT_MSB:FUNCT_LSB];

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter IMEM_DEPTH, default 64, SHALL set instruction memory size in 32-bit words (power of two, 4..1024).
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL set the PC value loaded at reset; it is word-aligned.
REQ-003 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 load_en  input  1  program-load write strobe.
REQ-006 load_addr  input  $clog2(IMEM_DEPTH)  word index for the load write.
REQ-007 load_data  input  32  instruction word for the load write.
REQ-008 run  input  1  start pulse.
REQ-009 branch  input  1  Branch output of the control unit.
REQ-010 zero  input  1  ALU zero flag.
REQ-011 instr  output  32  current instruction, 0 when instr_valid=0.
REQ-012 instr_valid  output  1  1 when instr is a live instruction; downstream gates RegWrite/MemWrite with it.
REQ-013 op  output  6  instr[31:26].
REQ-014 funct  output  6  instr[5:0].
REQ-015 rs, rt, rd  output  5 each  instr[25:21], [20:16], [15:11].
REQ-016 imm  output  16  instr[15:0].
REQ-017 pc  output  32  current PC.
REQ-018 pc_plus4  output  32  pc+4, modulo 2^32.
REQ-019 halted  output  1  1 while in HALT.

Function
REQ-020 FSM states IDLE, RUN, HALT; reset state IDLE.
REQ-021 IDLE: load_en=1 SHALL write load_data to imem[load_addr] at the clock edge; run=1 SHALL transition to RUN; both in the same cycle SHALL perform the write and transition.
REQ-022 RUN and HALT: load_en SHALL be ignored (memory unchanged); run SHALL be ignored.
REQ-023 Instruction read SHALL be combinational from pc[$clog2(IMEM_DEPTH)+1:2]; zero latency within the cycle (single-cycle datapath).
REQ-024 In RUN with pc[31:2] < IMEM_DEPTH: instr_valid=1; at the clock edge, pc <= (branch & zero) ? pc_plus4 + (sign-extended imm << 2) : pc_plus4, all modulo 2^32.
REQ-025 In RUN with pc[31:2] >= IMEM_DEPTH: instr_valid=0, pc holds, next state HALT.
REQ-026 HALT is sticky; only rst_n=0 leaves it; pc holds.
REQ-027 In IDLE and HALT: instr_valid=0; instr and all field outputs SHALL be 0; pc holds its value.
REQ-028 branch=1 with zero=0, or zero=1 with branch=0, SHALL yield sequential pc_plus4.
REQ-029 Branch target wrap-around (e.g. negative offset from pc=0) SHALL be modulo 2^32 with no error; an out-of-range result halts per REQ-025 on the next cycle.
REQ-030 pc_plus4 SHALL be driven in every state from the current pc.

Reset
REQ-031 rst_n=0 at a clock edge SHALL set pc=RESET_PC, state=IDLE, instr_valid=0, halted=0, instr/fields=0, regardless of state (including mid-RUN).
REQ-032 Instruction memory contents SHALL NOT be cleared by reset; a program survives reset and reruns on the next run pulse.
REQ-033 Memory content after power-up without loading is undefined; benches SHALL load before run.

Structure
REQ-034 Shared package mips_pkg SHALL hold the fetch-state enum, opcode constants (R-type 000000, LW 100011, SW 101011, BEQ 000100), and instruction field position constants.
REQ-035 Sub-module imem (one synchronous write port, one combinational read port, parameter DEPTH) SHALL hold the array; instr_fetch holds the FSM, PC register and next-PC logic.

Verification
REQ-036 Load words 0..3 with 0x8C010000, 0x00221820, 0xAC030004, 0x00000000, pulse run -> pc 0,4,8,12 on consecutive cycles, instr matches, instr_valid=1, op=0x23 in cycle 1.
REQ-037 BEQ 0x1000_0002 at pc=8 with branch=1, zero=1 -> next pc=0x14; same with zero=0 -> next pc=0x0C.
REQ-038 IMEM_DEPTH=64, run from pc=0xF8 with no branches -> pc 0xF8, 0xFC, then 0x100 with instr_valid=0, next cycle halted=1, pc stays 0x100; run pulses ignored.
REQ-039 BEQ imm=0xFFFF at pc=0 with branch=zero=1 -> next pc=0x0000_0000 (0+4-4); imm=0xFFFE -> pc=0xFFFF_FFFC, then HALT.
REQ-040 rst_n=0 mid-RUN at pc=0x10 -> next cycle pc=RESET_PC, IDLE, instr_valid=0; run -> program reexecutes from word 0 with unchanged contents.
REQ-041 load_en=1 during RUN to word 0 with 0xDEADBEEF -> after reset and run, word 0 still holds its original value.
